inst_encoder: RTL

Instruction encoder: the inverse of the immediate generator. It accepts decoded instruction fields plus a full 32-bit sign-extended immediate (the same value the immediate generator produces), range-checks the immediate, packs it into the RV32I bit layout and writes the word into instruction memory at an auto-incrementing byte address. It sits between a test/boot loader front end and the instruction-memory write port, and provides golden words for the immediate generator and decoder benches.

---
 rtl/inst_encoder_if.sv | 32 +++
 rtl/inst_encoder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/inst_encoder_if.sv
// Instruction encoder bus: field-bundle input handshake plus the
// instruction-memory write port.
//   master : loader/memory side (drives bundle fields, wr_ready)
//   slave  : encoder side (drives in_ready, wr_en, wr_addr, wr_data)
interface inst_encoder_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/inst_encoder.sv
// Instruction encoder: range-checks a sign-extended immediate, packs decoded
// fields into an RV32I word and writes it to instruction memory at an
// auto-incrementing byte address through a one-entry output register.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   clear      synchronous restart of address, count and error
//   bus        slave side of inst_encoder_if (bundle in, write port out)
//   err        sticky flag: an illegal bundle was dropped
//   inst_count words written since reset/clear (wraps at 16 bits)
module inst_encoder #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    inst_encoder_if.slave bus,
    output logic          err,
    output logic [15:0]   inst_count
);
    localparam int unsigned CNT_W = 16;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic              pend_q, pend_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    logic        in_ready_c;
    logic        accept_c;
    logic        wr_done_c;
    logic        legal_c;
    logic [31:0] enc_c;
    logic [31:0] imm;

    assign imm = bus.imm;

    // Pack fields per format and decide whether the immediate is representable.
    always_comb begin
        enc_c   = '0;
        legal_c = 1'b0;
        unique case (bus.fmt)
            FMT_R: begin
                enc_c   = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
                legal_c = 1'b1;
            end
            FMT_I: begin
                enc_c   = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                legal_c = (&imm[31:11]) || (~|imm[31:11]);
            end
            FMT_S: begin
                enc_c   = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
                legal_c = (&imm[31:11]) || (~|imm[31:11]);
            end
            FMT_B: begin
                enc_c   = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                           imm[4:1], imm[11], bus.opcode};
                legal_c = ((&imm[31:12]) || (~|imm[31:12])) && !imm[0];
            end
            FMT_U: begin
                enc_c   = {imm[31:12], bus.rd, bus.opcode};
                legal_c = ~|imm[11:0];
            end
            FMT_J: begin
                enc_c   = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
                legal_c = ((&imm[31:20]) || (~|imm[31:20])) && !imm[0];
            end
            default: begin
                enc_c   = '0;
                legal_c = 1'b0;
            end
        endcase
    end

    // Handshake: the single output slot frees up in the same cycle it drains.
    assign in_ready_c = !clear && (!pend_q || bus.wr_ready);
    assign accept_c   = bus.in_valid && in_ready_c;
    assign wr_done_c  = pend_q && bus.wr_ready;

    // Next state; clear wins over any simultaneous completion or accept.
    always_comb begin
        pend_d  = pend_q;
        data_d  = data_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        if (clear) begin
            pend_d  = 1'b0;
            addr_d  = BASE;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            if (wr_done_c) begin
                pend_d  = 1'b0;
                addr_d  = addr_q + ADDR_W'(4);
                count_d = count_q + CNT_W'(1);
            end
            if (accept_c) begin
                if (legal_c) begin
                    pend_d = 1'b1;
                    data_d = enc_c;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q  <= 1'b0;
            data_q  <= '0;
            addr_q  <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.wr_en    = pend_q;
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = data_q;
    assign err          = err_q;
    assign inst_count   = count_q;
endmodule
